// File: rtl/pc_spu_unit.sv
// Program counter register with +4/+8 taps, plus a small SPU with a 43-slot 4-bit color table.
// Latency: pc_out and the color table update one clk after their inputs; spu_result and the pc taps are combinational.
// Backpressure: none. Every cycle is accepted. Optional SCALE op is built only when PC_SPU_SCALE_EN is defined.
module pc_spu_unit (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  pc_in,
    output logic [31:0]  pc_out,
    output logic [31:0]  pc_plus4,
    output logic [31:0]  pc_plus8,
    input  logic [31:0]  src_a,
    input  logic [31:0]  rd3,
    input  logic [31:0]  rd4,
    input  logic [31:0]  src_b,
    input  logic [11:0]  spu_code,
    output logic [171:0] color_positions,
    output logic [31:0]  spu_result
);

    localparam int unsigned NUM_SLOTS = 43;

    typedef enum logic [3:0] {
        OP_NOP      = 4'h0,
        OP_ADD3     = 4'h1,
        OP_SCALE    = 4'h2,
        OP_MIN      = 4'h3,
        OP_MAX      = 4'h4,
        OP_CLAMP    = 4'h5,
        OP_SETCOLOR = 4'h6,
        OP_GETCOLOR = 4'h7,
        OP_CLEAR    = 4'h8
    } spu_op_t;

    logic [3:0]  op;
    logic [5:0]  idx;
    logic [1:0]  sel;
    logic [31:0] opb;
    logic [31:0] scale_res;
    logic        idx_ok;
    logic [3:0]  slot_q [NUM_SLOTS];

    assign op     = spu_code[11:8];
    assign idx    = spu_code[7:2];
    assign sel    = spu_code[1:0];
    assign idx_ok = (idx <= 6'd42);

    assign pc_plus4 = pc_out + 32'd4;
    assign pc_plus8 = pc_out + 32'd8;

    // Flatten the slot array onto the output bus, slot k at bits [4k+3:4k].
    for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_color_out
        assign color_positions[4*k+3:4*k] = slot_q[k];
    end

    // Second-operand mux; sel=11 uses the immediate idx field.
    always_comb begin
        opb = src_b;
        case (sel)
            2'b00: opb = src_b;
            2'b01: opb = rd3;
            2'b10: opb = rd4;
            2'b11: opb = {26'd0, idx};
            default: opb = src_b;
        endcase
    end

`ifdef PC_SPU_SCALE_EN
    // 16x16 fixed-point scale; the 32-bit product is shifted down by 8 (upper pad bits are zero).
    logic [31:0] prod_full;
    assign prod_full = {16'd0, src_a[15:0]} * {16'd0, opb[15:0]};
    assign scale_res = prod_full >> 8;
`else
    assign scale_res = 32'd0;
`endif

    // SPU result selection by op; unused opcodes return zero.
    always_comb begin
        spu_result = 32'd0;
        case (op)
            OP_ADD3:     spu_result = src_a + rd3 + rd4;
            OP_SCALE:    spu_result = scale_res;
            OP_MIN:      spu_result = (src_a < opb) ? src_a : opb;
            OP_MAX:      spu_result = (src_a > opb) ? src_a : opb;
            OP_CLAMP:    spu_result = (src_a < 32'd255) ? src_a : 32'd255;
            OP_SETCOLOR: spu_result = src_a;
            OP_GETCOLOR: spu_result = idx_ok ? {28'd0, slot_q[idx]} : 32'd0;
            default:     spu_result = 32'd0;
        endcase
    end

    // PC register and color table; reset overrides any write on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_out <= 32'd0;
            for (int i = 0; i < NUM_SLOTS; i++) slot_q[i] <= 4'd0;
        end else begin
            pc_out <= pc_in;
            if (op == OP_CLEAR) begin
                for (int i = 0; i < NUM_SLOTS; i++) slot_q[i] <= 4'd0;
            end else if (op == OP_SETCOLOR && idx_ok) begin
                slot_q[idx] <= opb[3:0];
            end
        end
    end

endmodule

// File: tb/tb_pc_spu_unit.sv
module tb_pc_spu_unit;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  pc_in, pc_out, pc_plus4, pc_plus8;
    logic [31:0]  src_a, rd3, rd4, src_b;
    logic [11:0]  spu_code;
    logic [171:0] color_positions;
    logic [31:0]  spu_result;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    longint unsigned m_pc;
    int unsigned     m_col [43];

    always #5 clk = ~clk;

    pc_spu_unit dut (
        .clk(clk), .reset(reset), .pc_in(pc_in), .pc_out(pc_out),
        .pc_plus4(pc_plus4), .pc_plus8(pc_plus8),
        .src_a(src_a), .rd3(rd3), .rd4(rd4), .src_b(src_b),
        .spu_code(spu_code), .color_positions(color_positions),
        .spu_result(spu_result)
    );

    task automatic chk(input string tag, input logic [171:0] got, input logic [171:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic longint unsigned model_opb(input int unsigned sel, input int unsigned idx,
                                                  input longint unsigned b, r3, r4);
        case (sel)
            0: return b;
            1: return r3;
            2: return r4;
            default: return idx;
        endcase
    endfunction

    function automatic logic [31:0] model_result(input int unsigned op, input int unsigned idx, input int unsigned sel,
                                                 input longint unsigned a, r3, r4, b);
        longint unsigned ob;
        longint unsigned r;
        ob = model_opb(sel, idx, b, r3, r4);
        case (op)
            1: r = (a + r3 + r4) % (64'd1 << 32);
`ifdef PC_SPU_SCALE_EN
            2: r = ((a % 65536) * (ob % 65536)) / 256;
`endif
            3: r = (a < ob) ? a : ob;
            4: r = (a > ob) ? a : ob;
            5: r = (a > 255) ? 255 : a;
            6: r = a;
            7: r = (idx <= 42) ? m_col[idx] : 0;
            default: r = 0;
        endcase
        return r[31:0];
    endfunction

    function automatic logic [171:0] model_table();
        logic [171:0] v;
        v = '0;
        for (int k = 0; k < 43; k++) v[4*k +: 4] = m_col[k][3:0];
        return v;
    endfunction

    // Apply one cycle of stimulus, check combinational result, clock, then check registered state.
    task automatic step(input logic rst, input logic [31:0] pc, a, r3v, r4v, b,
                        input logic [3:0] op, input logic [5:0] idx, input logic [1:0] sel);
        longint unsigned ob;
        reset = rst; pc_in = pc; src_a = a; rd3 = r3v; rd4 = r4v; src_b = b;
        spu_code = {op, idx, sel};
        #1;
        chk("spu_result", {140'd0, spu_result}, {140'd0, model_result(op, idx, sel, a, r3v, r4v, b)});
        ob = model_opb(sel, idx, b, r3v, r4v);
        @(posedge clk);
        if (rst) begin
            m_pc = 0;
            for (int k = 0; k < 43; k++) m_col[k] = 0;
        end else begin
            m_pc = pc;
            if (op == 4'h8) for (int k = 0; k < 43; k++) m_col[k] = 0;
            else if (op == 4'h6 && idx <= 42) m_col[idx] = ob % 16;
        end
        #1;
        chk("pc_out",   {140'd0, pc_out},   {140'd0, m_pc[31:0]});
        chk("pc_plus4", {140'd0, pc_plus4}, {140'd0, 32'((m_pc + 4) % (64'd1 << 32))});
        chk("pc_plus8", {140'd0, pc_plus8}, {140'd0, 32'((m_pc + 8) % (64'd1 << 32))});
        chk("color_positions", color_positions, model_table());
    endtask

    initial begin
        logic [3:0]  rop;
        logic [5:0]  ridx;
        int unsigned r;
        logic [171:0] tmp;
        m_pc = 0;
        for (int k = 0; k < 43; k++) m_col[k] = 0;
        reset = 1'b1; pc_in = '0; src_a = '0; rd3 = '0; rd4 = '0; src_b = '0; spu_code = '0;
        @(negedge clk);

        // Reset state
        step(1, 32'h0, 0, 0, 0, 0, 4'h0, 6'd0, 2'd0);
        chk("rst_pc_plus4", {140'd0, pc_plus4}, 172'd4);
        chk("rst_pc_plus8", {140'd0, pc_plus8}, 172'd8);
        chk("rst_colors", color_positions, 172'd0);

        // PC load, reset override, wrap
        step(0, 32'h100, 0, 0, 0, 0, 4'h0, 6'd0, 2'd0);
        chk("pc_0x100", {140'd0, pc_out}, 172'h100);
        chk("pc4_0x104", {140'd0, pc_plus4}, 172'h104);
        step(1, 32'h200, 0, 0, 0, 0, 4'h0, 6'd0, 2'd0);
        chk("pc_reset_wins", {140'd0, pc_out}, 172'd0);
        step(0, 32'hFFFF_FFFC, 0, 0, 0, 0, 4'h0, 6'd0, 2'd0);
        chk("wrap_plus4", {140'd0, pc_plus4}, 172'h0);
        chk("wrap_plus8", {140'd0, pc_plus8}, 172'h4);

        // Arithmetic ops
        step(0, 32'h10, 10, 20, 30, 0, 4'h1, 6'd0, 2'd0);
        step(0, 32'h14, 300, 0, 0, 0, 4'h5, 6'd0, 2'd0);
        step(0, 32'h18, 7, 5, 0, 0, 4'h3, 6'd0, 2'd1);
        step(0, 32'h1C, 32'hFFFF_FFFF, 1, 1, 0, 4'h1, 6'd0, 2'd0);
        step(0, 32'h20, 3, 0, 0, 0, 4'h4, 6'd40, 2'd3);
        step(0, 32'h24, 32'h200, 0, 0, 32'h80, 4'h2, 6'd0, 2'd0);

        // Color table: write, read, out-of-range, clear, reset vs write
        step(0, 32'h28, 0, 0, 0, 32'hA, 4'h6, 6'd3, 2'd0);
        tmp = 172'hA;
        chk("set_slot3", color_positions, tmp << 12);
        step(0, 32'h2C, 0, 0, 0, 0, 4'h7, 6'd3, 2'd0);
        chk("get_slot3", {140'd0, spu_result}, 172'hA);
        step(0, 32'h30, 0, 0, 0, 32'h5, 4'h6, 6'd50, 2'd0);
        step(0, 32'h34, 0, 0, 0, 32'hF, 4'h6, 6'd42, 2'd0);
        step(0, 32'h38, 0, 0, 0, 32'h7, 4'h6, 6'd0, 2'd0);
        step(0, 32'h3C, 0, 0, 0, 0, 4'h7, 6'd42, 2'd0);
        step(0, 32'h40, 0, 0, 0, 0, 4'h7, 6'd43, 2'd0);
        step(0, 32'h44, 0, 0, 0, 0, 4'h8, 6'd0, 2'd0);
        chk("clear_all", color_positions, 172'd0);
        step(1, 32'h48, 0, 0, 0, 32'h9, 4'h6, 6'd5, 2'd0);
        chk("reset_vs_set", color_positions, 172'd0);

        // Randomized traffic biased towards table operations
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 9);
            if (r < 3)      rop = 4'h6;
            else if (r < 6) rop = 4'h7;
            else            rop = 4'($urandom_range(0, 15));
            if (rop == 4'h8 && $urandom_range(0, 3) != 0) rop = 4'h6;
            ridx = 6'($urandom_range(0, 47));
            step(($urandom_range(0, 39) == 0), $urandom,
                 ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 400)),
                 $urandom, $urandom, $urandom, rop, ridx, 2'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
